// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between the decoder/ROM side and the program-counter sequencer.
interface pc_sequencer_if #(
  parameter int unsigned PW = 10,
  parameter int unsigned IW = 9,
  parameter int unsigned SD = 4
);
  localparam int unsigned DW = $clog2(SD + 1);

  logic          stall;
  logic [IW-1:0] instr;
  logic          jump_en;
  logic          call_en;
  logic          ret_en;
  logic          branch_taken;
  logic [7:0]    branch_off;
  logic          branch_skip;
  logic          halt_req;

  logic [PW-1:0] PC;
  logic          read_jump;
  logic          halted;
  logic [DW-1:0] stack_depth;
  logic          stack_ovf;
  logic          stack_unf;

  // Decoder/ROM side: drives controls, observes the fetch state
  modport master (
    output stall, instr, jump_en, call_en, ret_en, branch_taken, branch_off,
           branch_skip, halt_req,
    input  PC, read_jump, halted, stack_depth, stack_ovf, stack_unf
  );

  // Sequencer side
  modport slave (
    input  stall, instr, jump_en, call_en, ret_en, branch_taken, branch_off,
           branch_skip, halt_req,
    output PC, read_jump, halted, stack_depth, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, relative branches, skips,
// 2-word jump/call with an operand-fetch state, return stack, stall and halt.
module pc_sequencer #(
  parameter int unsigned PW         = 10,
  parameter int unsigned IW         = 9,
  parameter int unsigned SD         = 4,
  parameter int unsigned START_ADDR = 0
) (
  input  logic            CLK,
  input  logic            reset_n,
  pc_sequencer_if.slave   bus
);
  localparam int unsigned DW = $clog2(SD + 1);
  localparam int unsigned AW = (SD > 1) ? $clog2(SD) : 1;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_OPERAND = 2'd1,
    S_HALT    = 2'd2
  } state_e;

  state_e        state_q;
  logic [PW-1:0] pc_q;
  logic [DW-1:0] depth_q;
  logic          call_q;
  logic          ovf_q;
  logic          unf_q;
  logic [PW-1:0] stack_q [SD];

  logic [PW-1:0] target_c;
  logic [PW-1:0] pc_inc_c;
  logic [PW-1:0] pc_skip_c;
  logic [PW-1:0] pc_br_c;
  logic [PW-1:0] tos_c;
  logic          stack_full_c;
  logic          stack_empty_c;

  // Jump target keeps the upper PC bits of the operand word when the operand is narrower
  generate
    if (PW > IW) begin : g_target_page
      assign target_c = {pc_q[PW-1:IW], bus.instr};
    end else begin : g_target_full
      assign target_c = bus.instr[PW-1:0];
    end
  endgenerate

  // Next-address candidates; all arithmetic wraps modulo 2^PW
  always_comb begin
    pc_inc_c      = pc_q + PW'(1);
    pc_skip_c     = pc_q + PW'(2);
    pc_br_c       = pc_q + PW'($signed(bus.branch_off));
    tos_c         = stack_q[AW'(depth_q - DW'(1))];
    stack_full_c  = (depth_q == DW'(SD));
    stack_empty_c = (depth_q == DW'(0));
  end

  // Sequencer FSM, PC, return stack and sticky error flags
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_RUN;
      pc_q    <= PW'(START_ADDR);
      depth_q <= '0;
      call_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < int'(SD); i++) stack_q[i] <= '0;
    end else if (!bus.stall) begin
      case (state_q)
        S_RUN: begin
          if (bus.halt_req) begin
            state_q <= S_HALT;
          end else if (bus.ret_en) begin
            if (stack_empty_c) begin
              unf_q   <= 1'b1;
              state_q <= S_HALT;
            end else begin
              pc_q    <= tos_c;
              depth_q <= depth_q - DW'(1);
            end
          end else if (bus.call_en || bus.jump_en) begin
            pc_q    <= pc_inc_c;
            call_q  <= bus.call_en;
            state_q <= S_OPERAND;
          end else if (bus.branch_taken) begin
            pc_q <= pc_br_c;
          end else if (bus.branch_skip) begin
            pc_q <= pc_skip_c;
          end else begin
            pc_q <= pc_inc_c;
          end
        end
        S_OPERAND: begin
          if (call_q && stack_full_c) begin
            ovf_q   <= 1'b1;
            state_q <= S_HALT;
          end else begin
            if (call_q) begin
              stack_q[AW'(depth_q)] <= pc_inc_c;
              depth_q               <= depth_q + DW'(1);
            end
            pc_q    <= target_c;
            state_q <= S_RUN;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_HALT;
        end
      endcase
    end
  end

  // Outputs are registers or direct state decodes
  assign bus.PC          = pc_q;
  assign bus.read_jump   = (state_q == S_OPERAND);
  assign bus.halted      = (state_q == S_HALT);
  assign bus.stack_depth = depth_q;
  assign bus.stack_ovf   = ovf_q;
  assign bus.stack_unf   = unf_q;

endmodule
